rst_sequencer: RTL
==================

Name: rst_sequencer

Overview:
- Parametrised reset sequencer between the board-level clock/reset and the processor core plus its peripherals.
- Synchronises deassertion of the asynchronous active-low reset and holds all domains in reset for a minimum time.
- Releases NUM_CH per-channel resets in a fixed staggered order: channel 0 (core) first.
- Supports software re-sequencing, per-channel masking and a post-release cycle counter.

Parameters:
- NUM_CH, 3, number of reset channels.
- SYNC_STAGES, 2, reset-deassert synchroniser depth (>=2).
- HOLD, 8, cycles all channels stay low after synchronised deassert (>=1).
- STAGGER, 4, cycles between consecutive channel releases (>=1).
- CNT_W, 32, cycle_count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- sw_rst_req  in  1  single-cycle pulse; requests a full re-sequence.
- ch_mask  in  NUM_CH  1 = hold that channel in reset.
- rst_n_out  out  NUM_CH  per-channel active-low resets.
- all_released  out  1  high when every unmasked channel is released.
- seq_busy  out  1  high in any state other than RUN.
- cycle_count  out  CNT_W  cycles spent in RUN since the last sequence completed.

Behaviour:
- Reset values (reset low):
  - rst_n_out = 0, asserted asynchronously with no clock required.
  - all_released = 0, seq_busy = 1, cycle_count = 0, FSM = ASSERT, synchroniser = 0.
- Deassert: reset rising passes through a SYNC_STAGES flop chain. The FSM leaves ASSERT for HOLD when the chain output goes high.
- FSM states: ASSERT -> HOLD -> RELEASE -> RUN.
  - HOLD: counts HOLD cycles, then enters RELEASE.
  - RELEASE:
    - Slot counter s starts at 0 on entry.
    - Channel i is released when s == i*STAGGER, unless ch_mask[i] is set.
    - Enters RUN on the cycle the last channel slot (NUM_CH-1) is reached.
- Timing: count the first rising edge after reset deasserts as edge 1. Then rst_n_out[i] rises on edge SYNC_STAGES+HOLD+i*STAGGER. With defaults: edges 10, 14, 18.
- all_released:
  - Registered.
  - Rises on the same edge as the last unmasked release, but no earlier than entry to RUN.
  - Drops in the same cycle as any unmasked channel is asserted.
- cycle_count:
  - Held at 0 outside RUN.
  - Increments on each edge in RUN, so it reads 1 one edge after RUN entry.
  - Saturates at all-ones.
- Software re-sequence:
  - sw_rst_req in RUN: next edge sets all rst_n_out = 0, clears cycle_count and enters HOLD.
  - sw_rst_req in HOLD or RELEASE: returns to HOLD with the counter cleared and all channels low.
  - sw_rst_req in ASSERT: ignored.
- Masking:
  - ch_mask change in RUN takes effect on the next edge: set forces that channel low, clear releases it. This does not affect other channels or cycle_count.
  - Bit cleared during RELEASE after that channel's slot has passed: channel releases on the next edge.
  - Bit cleared before its slot: channel waits for its slot.
- All channels masked: the sequence still runs; all_released rises on RUN entry.
- reset low at any time overrides everything: immediate return to ASSERT state and outputs.

Optional Feature:
- Macro: RST_SEQ_WDT_EN.
- Defined:
  - Adds input heartbeat (1), input wdt_limit (16) and output wdt_fired (1, reset 0).
  - In RUN, a 16-bit counter clears on heartbeat and increments otherwise.
  - When the counter reaches wdt_limit (wdt_limit != 0), the block behaves exactly as sw_rst_req and sets wdt_fired sticky.
  - wdt_fired clears only on reset.
  - wdt_limit == 0 disables the watchdog.
- Undefined: ports absent; no watchdog logic.

Decomposition:
- Shared package rst_seq_pkg holds:
  - FSM state typedef: ST_ASSERT, ST_HOLD, ST_RELEASE, ST_RUN.
  - Default parameter constants.
  - WDT counter width constant.
- One natural sub-module: rst_sync, the SYNC_STAGES asynchronous-assert/synchronous-deassert flop chain.

Test Plan:
- Defaults, mask 0, reset pulse low then high:
  - rst_n_out bits rise at edges 10, 14, 18.
  - all_released rises at edge 18; cycle_count = 5 at edge 23.
- ch_mask = 3'b010 from start:
  - ch0 rises at edge 10, ch2 at edge 18, ch1 stays 0; all_released at 18.
  - Clearing the mask in RUN releases ch1 on the next edge.
- sw_rst_req pulse at RUN cycle 20:
  - Next edge: all 0, cycle_count 0, seq_busy 1.
  - ch0 rises HOLD edges after entering HOLD; the rest follow at +4 and +8.
- reset low mid-RELEASE (after ch0 released):
  - All outputs 0 immediately, without a clock edge.
  - On release, the full sequence restarts from edge 1.
- sw_rst_req during HOLD at cycle 5 of 8: HOLD restarts; ch0 released 8 cycles after the request edge.
- RST_SEQ_WDT_EN with wdt_limit = 16 and no heartbeat in RUN:
  - Re-sequence starts at RUN cycle 16 and wdt_fired = 1.
  - With a heartbeat every 10 cycles: no fire.

Source files
------------

// File: rtl/rst_sequencer_pkg.sv
// Shared types and default parameters for the reset sequencer.
// The optional watchdog is built only when RST_SEQ_WDT_EN is defined.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } rst_state_e;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD        = 8;
  localparam int DEF_STAGGER     = 4;
  localparam int DEF_CNT_W       = 32;
  localparam int WDT_W           = 16;

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the reset sequencer and its controller.
// Watchdog signals exist only when RST_SEQ_WDT_EN is defined.
interface rst_sequencer_if
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              sw_rst_req;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] rst_n_out;
  logic              all_released;
  logic              seq_busy;
  logic [CNT_W-1:0]  cycle_count;

`ifdef RST_SEQ_WDT_EN
  logic              heartbeat;
  logic [WDT_W-1:0]  wdt_limit;
  logic              wdt_fired;

  modport master (
    output sw_rst_req, ch_mask,
    output heartbeat, wdt_limit,
    input  rst_n_out, all_released,
    input  seq_busy, cycle_count,
    input  wdt_fired
  );

  modport slave (
    input  sw_rst_req, ch_mask,
    input  heartbeat, wdt_limit,
    output rst_n_out, all_released,
    output seq_busy, cycle_count,
    output wdt_fired
  );
`else
  modport master (
    output sw_rst_req, ch_mask,
    input  rst_n_out, all_released,
    input  seq_busy, cycle_count
  );

  modport slave (
    input  sw_rst_req, ch_mask,
    output rst_n_out, all_released,
    output seq_busy, cycle_count
  );
`endif

endinterface

// File: rtl/rst_sequencer_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts
// after STAGES clock edges.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [STAGES-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= {q[STAGES-2:0], 1'b1};
  end

  assign rst_n_sync = q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staggered per-channel reset release with software re-sequence,
// masking and RUN cycle counter; watchdog under RST_SEQ_WDT_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD        = DEF_HOLD,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  rst_sequencer_if.slave bus
);

  localparam int LAST_SLOT = (NUM_CH - 1) * STAGGER;
  localparam int CNT_MAX   =
    (HOLD > LAST_SLOT) ? HOLD : LAST_SLOT;
  localparam int SEQ_W     = $clog2(CNT_MAX + 1);

  rst_state_e        state;
  logic [SEQ_W-1:0]  seq_cnt;
  logic [SEQ_W-1:0]  slot_nxt;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] hit_nxt;
  logic [NUM_CH-1:0] rst_q;
  logic              all_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sync_n;
  logic              restart;
  logic              go_rel;
  logic              last_hit;
  logic              run_nxt;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (reset),
    .rst_n_sync(sync_n)
  );

`ifdef RST_SEQ_WDT_EN
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_fired;
  logic             wdt_trip;

  assign wdt_trip = state == ST_RUN
                 && bus.wdt_limit != '0
                 && wdt_cnt >= bus.wdt_limit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (state != ST_RUN || bus.heartbeat || wdt_trip)
        wdt_cnt <= '0;
      else if (wdt_cnt != '1)
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      if (wdt_trip) wdt_fired <= 1'b1;
    end
  end

  assign bus.wdt_fired = wdt_fired;
  assign restart = state != ST_ASSERT
                && (bus.sw_rst_req || wdt_trip);
`else
  assign restart = state != ST_ASSERT && bus.sw_rst_req;
`endif

  // ASSERT exit already spent one cycle after sync deassert
  assign go_rel =
    (state == ST_HOLD && seq_cnt == SEQ_W'(HOLD - 1))
    || (state == ST_ASSERT && sync_n && HOLD == 1);

  assign slot_nxt = seq_cnt + SEQ_W'(1);
  assign last_hit = slot_nxt == SEQ_W'(LAST_SLOT);

  assign run_nxt = !restart && (
    state == ST_RUN
    || (state == ST_RELEASE && last_hit)
    || (go_rel && NUM_CH == 1));

  always_comb begin
    hit_nxt = hit;
    if (restart) begin
      hit_nxt = '0;
    end else if (go_rel) begin
      hit_nxt[0] = 1'b1;
    end else if (state == ST_RELEASE) begin
      for (int i = 0; i < NUM_CH; i++)
        if (slot_nxt == SEQ_W'(i * STAGGER))
          hit_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_ASSERT;
      seq_cnt <= '0;
      hit     <= '0;
      rst_q   <= '0;
      all_q   <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      hit    <= hit_nxt;
      rst_q  <= hit_nxt & ~bus.ch_mask;
      all_q  <= run_nxt & (&(hit_nxt | bus.ch_mask));
      busy_q <= ~run_nxt;

      if (state == ST_RUN && !restart)
        cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;

      if (restart) begin
        state   <= ST_HOLD;
        seq_cnt <= '0;
      end else if (go_rel) begin
        state   <= (NUM_CH == 1) ? ST_RUN : ST_RELEASE;
        seq_cnt <= '0;
      end else begin
        unique case (state)
          ST_ASSERT: begin
            if (sync_n) begin
              state   <= ST_HOLD;
              seq_cnt <= SEQ_W'(1);
            end
          end
          ST_HOLD: seq_cnt <= slot_nxt;
          ST_RELEASE: begin
            seq_cnt <= slot_nxt;
            if (last_hit) state <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rst_n_out    = rst_q;
  assign bus.all_released = all_q;
  assign bus.seq_busy     = busy_q;
  assign bus.cycle_count  = cnt_q;

endmodule
